fp_mul_operand_unpack: RTL

Input stage of the FP32 approximate-multiplier datapath. Accepts packed IEEE-754 single-precision operand pairs over a valid/ready handshake and splits each operand into the sign, exponent and mantissa fields the multiplier core consumes. Classifies each operand and flags pairs that need special-case handling, so the downstream packer can bypass the approximate mantissa result. Registered output with a 2-entry skid buffer, full throughput.

---
 rtl/fp_mul_pkg.sv | 25 ++
 rtl/fp_classify.sv | 51 +++++
 rtl/fp_mul_operand_unpack.sv | 115 +++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared FP32 field widths and operand class codes for the multiplier datapath
package fp_mul_pkg;

    // IEEE-754 single-precision field layout
    localparam int FP32_EXP_WIDTH  = 8;
    localparam int FP32_MANT_WIDTH = 23;
    localparam int FP32_WIDTH      = 1 + FP32_EXP_WIDTH + FP32_MANT_WIDTH;

    // Exponent value reserved for INF/NAN encodings
    localparam logic [FP32_EXP_WIDTH-1:0] FP32_EXP_ONES = '1;

    // Operand class codes; 5..7 are never produced
    localparam int FP_CLASS_WIDTH = 3;
    localparam logic [FP_CLASS_WIDTH-1:0] FP_CLASS_ZERO   = 3'd0;
    localparam logic [FP_CLASS_WIDTH-1:0] FP_CLASS_NORM   = 3'd1;
    localparam logic [FP_CLASS_WIDTH-1:0] FP_CLASS_DENORM = 3'd2;
    localparam logic [FP_CLASS_WIDTH-1:0] FP_CLASS_INF    = 3'd3;
    localparam logic [FP_CLASS_WIDTH-1:0] FP_CLASS_NAN    = 3'd4;

    // Any class other than NORM sends the pair down the packer's bypass path
    function automatic logic fp_class_is_special(input logic [FP_CLASS_WIDTH-1:0] cls);
        return cls != FP_CLASS_NORM;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - splits one packed FP word into fields and classifies it (FP_UNPACK_DAZ_EN flushes denormals)
module fp_classify
    import fp_mul_pkg::*;
#(
    parameter int EXP_WIDTH  = FP32_EXP_WIDTH,
    parameter int MANT_WIDTH = FP32_MANT_WIDTH
) (
    input  logic [EXP_WIDTH+MANT_WIDTH:0]  word,
    output logic                           sign,
    output logic [EXP_WIDTH-1:0]           exp_field,
    output logic [MANT_WIDTH-1:0]          mant_field,
    output logic [FP_CLASS_WIDTH-1:0]      cls,
    output logic                           special
);

    logic [EXP_WIDTH-1:0]      raw_exp;
    logic [MANT_WIDTH-1:0]     raw_mant;
    logic [FP_CLASS_WIDTH-1:0] raw_cls;

    assign raw_exp  = word[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
    assign raw_mant = word[MANT_WIDTH-1:0];

    // Classify the raw encoding; special is taken before any denormal flush so
    // a flushed denormal still routes through the bypass path
    always_comb begin
        raw_cls = FP_CLASS_NORM;
        if (raw_exp == '0) begin
            raw_cls = (raw_mant == '0) ? FP_CLASS_ZERO : FP_CLASS_DENORM;
        end else if (raw_exp == {EXP_WIDTH{1'b1}}) begin
            raw_cls = (raw_mant == '0) ? FP_CLASS_INF : FP_CLASS_NAN;
        end
    end

    assign special = fp_class_is_special(raw_cls);
    assign sign    = word[EXP_WIDTH+MANT_WIDTH];

    // Forward fields; with denormals-are-zero a DENORM becomes a signed zero
    always_comb begin
        exp_field  = raw_exp;
        mant_field = raw_mant;
        cls        = raw_cls;
`ifdef FP_UNPACK_DAZ_EN
        if (raw_cls == FP_CLASS_DENORM) begin
            exp_field  = '0;
            mant_field = '0;
            cls        = FP_CLASS_ZERO;
        end
`endif
    end

endmodule

// File: rtl/fp_mul_operand_unpack.sv
// rtl/fp_mul_operand_unpack.sv - operand unpack stage with registered output and skid buffer (FP_UNPACK_DAZ_EN selects denormal flush)
module fp_mul_operand_unpack
    import fp_mul_pkg::*;
#(
    parameter int EXP_WIDTH  = FP32_EXP_WIDTH,
    parameter int MANT_WIDTH = FP32_MANT_WIDTH,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] in_x,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] in_y,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sign_x,
    output logic                          out_sign_y,
    output logic [EXP_WIDTH-1:0]          out_exp_x,
    output logic [EXP_WIDTH-1:0]          out_exp_y,
    output logic [MANT_WIDTH-1:0]         out_mantissa_x,
    output logic [MANT_WIDTH-1:0]         out_mantissa_y,
    output logic [FP_CLASS_WIDTH-1:0]     out_class_x,
    output logic [FP_CLASS_WIDTH-1:0]     out_class_y,
    output logic                          out_special,
    output logic [TAG_WIDTH-1:0]          out_tag
);

    // One unpacked operand: sign, exponent, mantissa, class
    localparam int OPND_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH + FP_CLASS_WIDTH;
    // Full pair entry: two operands, special flag, tag
    localparam int PAIR_WIDTH = 2 * OPND_WIDTH + 1 + TAG_WIDTH;

    logic                      sign_x, sign_y;
    logic [EXP_WIDTH-1:0]      exp_x, exp_y;
    logic [MANT_WIDTH-1:0]     mant_x, mant_y;
    logic [FP_CLASS_WIDTH-1:0] cls_x, cls_y;
    logic                      special_x, special_y;

    logic [PAIR_WIDTH-1:0]     new_pair;
    logic [PAIR_WIDTH-1:0]     or_pair;
    logic [PAIR_WIDTH-1:0]     sr_pair;
    logic                      or_valid;
    logic                      sr_valid;
    logic                      accept;
    logic                      transfer;

    fp_classify #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_classify_x (
        .word       (in_x),
        .sign       (sign_x),
        .exp_field  (exp_x),
        .mant_field (mant_x),
        .cls        (cls_x),
        .special    (special_x)
    );

    fp_classify #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_classify_y (
        .word       (in_y),
        .sign       (sign_y),
        .exp_field  (exp_y),
        .mant_field (mant_y),
        .cls        (cls_y),
        .special    (special_y)
    );

    assign new_pair = {sign_x, exp_x, mant_x, cls_x,
                       sign_y, exp_y, mant_y, cls_y,
                       special_x | special_y, in_tag};

    // in_ready comes straight from the skid flag so out_ready never reaches it
    assign in_ready = ~sr_valid;
    assign accept   = in_valid & ~sr_valid;
    assign transfer = or_valid & out_ready;

    // EMPTY/ONE/FULL storage walk, encoded directly by {sr_valid, or_valid}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
            or_pair  <= '0;
            sr_pair  <= '0;
        end else if (!or_valid) begin
            if (accept) begin
                or_pair  <= new_pair;
                or_valid <= 1'b1;
            end
        end else if (!sr_valid) begin
            if (accept && transfer) begin
                or_pair <= new_pair;
            end else if (accept) begin
                sr_pair  <= new_pair;
                sr_valid <= 1'b1;
            end else if (transfer) begin
                or_valid <= 1'b0;
            end
        end else if (transfer) begin
            or_pair  <= sr_pair;
            sr_pair  <= '0;
            sr_valid <= 1'b0;
        end
    end

    assign out_valid = or_valid;
    assign {out_sign_x, out_exp_x, out_mantissa_x, out_class_x,
            out_sign_y, out_exp_y, out_mantissa_y, out_class_y,
            out_special, out_tag} = or_pair;

endmodule
